// File: rtl/packet_receiver.sv
// UART 8N1 receiver that assembles PACKET_SIZE bytes (first byte in the MSBs) into one packet.
// Optional inter-byte timeout when PACKET_RECEIVER_TIMEOUT_EN is defined.
module packet_receiver #(
    parameter int PACKET_SIZE  = 2,
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rxd,
    output logic [8*PACKET_SIZE-1:0]  packet,
    output logic                      valid,
    output logic                      busy,
    output logic                      frame_err
);
    localparam int PW   = 8*PACKET_SIZE;
    localparam int HALF = CLKS_PER_BIT/2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BCW  = $clog2(PACKET_SIZE+1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic           rxd_meta, rxd_s, rxd_d;
    logic [1:0]     state;
    logic [CW-1:0]  clk_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic [BCW-1:0] byte_cnt;
    logic [PW-1:0]  pbuf, pbuf_next;
    logic           tick_half, tick_bit, timeout;

    assign tick_half = (clk_cnt == CW'(HALF-1));
    assign tick_bit  = (clk_cnt == CW'(CLKS_PER_BIT-1));
    assign pbuf_next = (pbuf << 8) | PW'(shreg);
    assign busy      = (state != IDLE) || (byte_cnt != '0);

    // rxd_d is one extra stage used only for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_d    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_d    <= rxd_s;
        end
    end

`ifdef PACKET_RECEIVER_TIMEOUT_EN
    localparam int TLIM = TIMEOUT_BITS*CLKS_PER_BIT;
    localparam int TW   = $clog2(TLIM+1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (state != IDLE || byte_cnt == '0)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + TW'(1);
    end

    assign timeout = (state == IDLE) && (byte_cnt != '0) && (tmo_cnt == TW'(TLIM-1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            byte_cnt  <= '0;
            pbuf      <= '0;
            packet    <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (timeout) begin
                        byte_cnt  <= '0;
                        frame_err <= 1'b1;
                    end
                    if (rxd_d && !rxd_s) state <= START;
                end
                START: begin
                    if (tick_half) begin
                        clk_cnt <= '0;
                        if (rxd_s) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (tick_bit) begin
                        clk_cnt <= '0;
                        shreg   <= {rxd_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                STOP: begin
                    // leave at mid stop bit so a following start edge is not missed
                    if (tick_bit) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        if (!rxd_s) begin
                            frame_err <= 1'b1;
                            byte_cnt  <= '0;
                            pbuf      <= '0;
                        end else if (byte_cnt == BCW'(PACKET_SIZE-1)) begin
                            packet   <= pbuf_next;
                            pbuf     <= '0;
                            valid    <= 1'b1;
                            byte_cnt <= '0;
                        end else begin
                            pbuf     <= pbuf_next;
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/packet_receiver.md
PACKET_RECEIVER -- requirements
Module: packet_receiver

Interface
REQ-001 SHALL provide parameter PACKET_SIZE, default 2, number of bytes per packet (>=1).
REQ-002 SHALL provide parameter CLKS_PER_BIT, default 104, clk cycles per UART bit (12 MHz / 115200 baud), >=4.
REQ-003 SHALL provide parameter TIMEOUT_BITS, default 20, inter-byte idle limit in bit periods (used only under REQ-024).
REQ-004 clk  input  1  system clock; one clock domain; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 rxd  input  1  UART serial input, asynchronous to clk, idle high.
REQ-007 packet  output  8*PACKET_SIZE  last complete packet.
REQ-008 valid  output  1  one-cycle pulse: packet updated.
REQ-009 busy  output  1  high while any byte of a packet is in progress.
REQ-010 frame_err  output  1  one-cycle pulse: bad stop bit or false start.

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer, reset value 1; all decoding uses the synchronized signal.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; reset state IDLE.
REQ-013 IDLE: falling edge of synchronized rxd -> START, bit counter cleared.
REQ-014 START: sample at CLKS_PER_BIT/2 (integer division); low -> DATA; high -> false start, frame_err pulse, -> IDLE, byte count unchanged.
REQ-015 DATA: sample every CLKS_PER_BIT cycles after the start mid-sample; 8 bits, LSB first; after bit 7 -> STOP.
REQ-016 STOP: sample one bit period after bit 7; high -> byte accepted; low -> frame_err pulse, partial packet discarded (byte count to 0), -> IDLE.
REQ-017 Byte ordering: first byte of a packet SHALL occupy packet[8*PACKET_SIZE-1 -: 8]; last byte occupies packet[7:0] (matches packet_sender order).
REQ-018 Bytes SHALL be assembled in an internal shift buffer; packet output changes only when the final byte is accepted, on the same edge valid asserts.
REQ-019 valid SHALL assert exactly one cycle, the cycle after the stop-bit sample of byte PACKET_SIZE; byte count wraps to 0 the same edge.
REQ-020 From the stop-bit sample the FSM SHALL return to IDLE immediately (half a stop bit early) so back-to-back bytes with one stop bit are received.
REQ-021 busy SHALL be high from the START entry of the first byte until valid or error; stays high between bytes of one packet.
REQ-022 No backpressure: a new packet overwrites packet; valid is never held.

Reset
REQ-023 While rst_n low: FSM IDLE, counters 0, buffer 0, packet 0, valid 0, busy 0, frame_err 0, synchronizer 1; reset mid-byte or mid-packet discards all partial data; first falling edge after release starts a new packet.

Configuration
REQ-024 Macro PACKET_RECEIVER_TIMEOUT_EN: when defined, if byte count >0 and the FSM stays in IDLE for TIMEOUT_BITS*CLKS_PER_BIT cycles, the partial packet SHALL be discarded (count to 0, busy low) with frame_err pulsed once; when undefined, no timeout logic exists and a partial packet waits indefinitely.

Verification
REQ-025 PACKET_SIZE=2, CLKS_PER_BIT=104: send 0x61 then 0x62 back-to-back 8N1 -> one valid pulse, packet=16'h6162, frame_err never high.
REQ-026 Send 0x61 with stop bit low -> frame_err one pulse, no valid; then 0x41, 0x42 -> packet=16'h4142.
REQ-027 40-cycle low glitch on idle rxd -> frame_err pulse from START, busy returns low, no byte counted.
REQ-028 rst_n low for 3 cycles during bit 4 of byte 2 -> all outputs 0 immediately; next packet 0x10,0x20 -> packet=16'h1020.
REQ-029 With PACKET_RECEIVER_TIMEOUT_EN: send 0x55, idle 25 bit times -> frame_err pulse, busy low; then 0xAA,0xBB -> packet=16'hAABB; without macro same stimulus -> packet=16'h55AA.
REQ-030 Three packets sent consecutively with zero idle gap -> three valid pulses, each spaced 20 bit periods, contents correct.
